// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the 5-stage RISC-V core.
// Owns the fetch PC, requests words from instruction memory over a req/ack
// handshake, buffers returned {inst, pc} pairs in a DEPTH-entry FIFO, and
// presents the FIFO head to decode with a valid/ready handshake. A redirect
// from execute flushes the queue and restarts fetch at the target.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   imem_req, imem_addr   fetch request and word-aligned byte address
//   imem_ack, imem_inst   memory response for the current request
//   redirect, redirect_pc execute-stage redirect and its target
//   valid_D, ready_D      decode handshake for the FIFO head
//   inst_D, pc_D,
//   pc_plus4_D            FIFO head payload (NOP/0/0 when empty)
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_D,
  input  logic        ready_D,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc_plus4_D
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [31:0]        fpc;
  logic [PTR_W-1:0]   rptr;
  logic [PTR_W-1:0]   wptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               pop;
  entry_t             head;

  // Request and handshake qualifiers; a redirect cycle never pushes or pops.
  always_comb begin
    imem_req  = !rst && (count < CNT_W'(DEPTH)) && !redirect;
    imem_addr = fpc;
    valid_D   = (count != '0);
    push      = imem_req && imem_ack;
    pop       = valid_D && ready_D && !redirect;
  end

  // Head presentation: NOP/zero pattern while the queue is empty.
  always_comb begin
    head       = mem[rptr];
    inst_D     = NOP;
    pc_D       = 32'h0;
    pc_plus4_D = 32'h0;
    if (valid_D) begin
      inst_D     = head.inst;
      pc_D       = head.pc;
      pc_plus4_D = head.pc + 32'd4;
    end
  end

  // Fetch PC, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc   <= RESET_PC;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (redirect) begin
      fpc   <= {redirect_pc[31:2], 2'b00};
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fpc  <= fpc + 32'd4;
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head never exposes stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= '{inst: imem_inst, pc: fpc};
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the 5-stage pipelined RISC-V core. It owns the fetch PC and issues word requests to the instruction memory over a req/ack handshake. Returned instructions are buffered with their PC in a small FIFO, and the FIFO head is presented to the decode pipeline register with a valid/ready handshake. A redirect input from the execute stage (taken branch or jump) flushes the queue and restarts fetch at the target, which lets the core tolerate multi-cycle instruction memory without a global stall.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; word aligned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  byte address of the requested word; always 4-aligned.
- imem_ack  in  1  memory returns imem_inst this cycle; only meaningful while imem_req=1.
- imem_inst  in  32  instruction word, valid when imem_req && imem_ack.
- redirect  in  1  execute-stage redirect (branch taken or jalr/jal).
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- valid_D  out  1  FIFO head holds a valid instruction.
- ready_D  in  1  decode accepts the head this cycle; this is the inverse of stall_D.
- inst_D  out  32  head instruction; 32'h0000_0013 (NOP) when valid_D=0.
- pc_D  out  32  head PC; 0 when valid_D=0.
- pc_plus4_D  out  32  pc_D + 4; 0 when valid_D=0.

## Operation
- State: fetch PC `fpc` (32b), FIFO storage of DEPTH × {inst, pc}, read and write pointers of log2(DEPTH) bits each, and count of log2(DEPTH)+1 bits.
- Request: imem_req = !rst && (count < DEPTH) && !redirect. imem_addr = fpc.
- Transfer: on a cycle with imem_req && imem_ack, {imem_inst, fpc} is written at wptr, wptr and fpc each advance (fpc += 4, mod 2^32), and count increments.
- Pop: on a cycle with valid_D && ready_D, rptr advances and count decrements. A push and pop in the same cycle leave count unchanged.
- Memory contract: the memory holds no state across a request. The address may change when req deasserts, and any in-flight access is abandoned.
- Redirect has the highest priority after rst. On a cycle with redirect=1:
  - count, rptr and wptr clear to 0.
  - fpc takes {redirect_pc[31:2],2'b00}.
  - Any same-cycle imem_ack data is discarded, since imem_req is 0.
  - Any same-cycle pop is ignored, although decode's own flush makes this a don't-care.
- Reset: fpc=RESET_PC, count=0, both pointers 0, and storage cleared to 0. During and after reset: imem_req=0 in the reset cycle, valid_D=0, inst_D=32'h13, pc_D=0, pc_plus4_D=0.
- Outputs are combinational reads of the FIFO head. There is no bypass from imem_inst to the *_D outputs.

## Timing
- Fetch-to-decode latency: a transfer in cycle n raises valid_D with that entry in cycle n+1.
- Throughput: with imem_ack tied to 1 and ready_D=1, one instruction per cycle. The PC sequence is fpc, fpc+4, …
- Full: when count==DEPTH, imem_req=0. A pop in cycle n frees a slot, so imem_req=1 in cycle n+1. The queue never pushes at full, even when a pop happens in the same cycle.
- Empty: when count==0, valid_D=0 and the NOP pattern is driven. A ready_D asserted while empty has no effect.
- Redirect in cycle n: imem_req=0 in cycle n. In cycle n+1, imem_req=1 with imem_addr=redirect target, and valid_D=0. The earliest valid_D for the target is n+2.
- Wrap-around: pointers wrap modulo DEPTH, and fpc wraps from 32'hFFFF_FFFC to 0.
- rst and redirect asserted together: rst wins, and fpc=RESET_PC.

## Test plan
- Reset, imem_ack=1, ready_D=1, RESET_PC=0 → imem_addr sequence 0,4,8,…; valid_D first high one cycle after reset release with pc_D=0; pc_plus4_D=4.
- ready_D=0 with imem_ack=1 → exactly 4 pushes (pc 0..C), then imem_req=0. Raise ready_D for one cycle → pop pc_D=0; imem_req=1 next cycle with addr 0x10.
- imem_ack pulses every third cycle, ready_D=1 → every instruction appears exactly once, in PC order, with no duplicates or drops.
- FIFO holding 3 entries, redirect=1 with redirect_pc=0x103 in the same cycle as imem_ack=1 → that data is dropped; next cycle valid_D=0 and imem_addr=0x100; pc_D=0x100 the cycle after.
- Simultaneous push and pop at count=2 → count stays 2; order is preserved across a pointer wrap over more than 12 instructions.
- Assert rst mid-stream with a full FIFO → next cycle valid_D=0, inst_D=0x13, imem_addr=RESET_PC.
